pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit; next generation of the CPU's PC block.
- Adds over the current PC block:
  - configurable width and shift amount
  - conditional-branch fall-through
  - hardware return-address stack for call/ret
  - pipeline stall input
  - trap state machine for stack overflow/underflow
- Sits between the control unit and instruction memory; drives the fetch address.

Parameters:
WIDTH, 16, PC/address width in bits
STACK_DEPTH, 8, return-stack entries (power of two, >=2)
SHIFT, 4, left-shift amount for scaled modes 101/111
RESET_VECTOR, 0, PC value after reset
TRAP_VECTOR, 16'hFFF0 (truncated/zero-extended to WIDTH), PC loaded on trap entry

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pcSrc  in  3  next-PC mode select
immAddr  in  WIDTH  immediate address/offset
ra  in  WIDTH  register return address
mary  in  WIDTH  register operand for modes 100/101
comp  in  1  branch condition result (1 = taken)
pcWrite  in  1  PC update request from control
stall  in  1  pipeline stall; freezes all state
call  in  1  push pcOut+1 on qualified write
ret  in  1  pop stack into PC on qualified write
trapAck  in  1  leave TRAP state
pcOut  out  WIDTH  current PC
stackDepth  out  clog2(STACK_DEPTH)+1  entries on stack
trap  out  1  high while in TRAP state
trapCause  out  2  00 none, 01 overflow, 10 underflow

Behaviour:
- Reset (reset==0, async):
  - pcOut=RESET_VECTOR, stackDepth=0, trap=0, trapCause=00, state=RUN.
  - All stack entries cleared.
- States: RUN, TRAP. Reset enters RUN.
- Qualified write: qw = pcWrite & ~stall & (state==RUN). One-cycle latency: pcOut updates on the rising edge after qw is sampled.
- Next-PC table (when ret==0). All arithmetic is modulo 2^WIDTH; carries are discarded.
  - 000: pcOut+1
  - 001: pcOut+immAddr
  - 010: immAddr
  - 011: ra
  - 100: mary
  - 101: pcOut+(mary<<SHIFT)
  - 110: comp ? immAddr : pcOut+1
  - 111: comp ? (immAddr<<SHIFT) : pcOut+1
  - Modes 110/111 with comp==0 fall through to pcOut+1. The PC is not held.
- ret==1 with qw: next PC = stack top, stackDepth-1. pcSrc is ignored.
- call==1 with qw: push pcOut+1 (not the target), stackDepth+1. Next PC comes from pcSrc.
- call & ret in the same qw cycle:
  - next PC = old top.
  - The top entry is overwritten with pcOut+1.
  - stackDepth unchanged.
- Overflow: call without ret, qw, stackDepth==STACK_DEPTH.
  - No push. pcOut<=TRAP_VECTOR, state<=TRAP, trapCause<=01.
- Underflow: ret (with or without call), qw, stackDepth==0.
  - No pop or push. pcOut<=TRAP_VECTOR, state<=TRAP, trapCause<=10.
- TRAP state:
  - trap=1; pcWrite/call/ret are ignored; pcOut holds TRAP_VECTOR.
  - trapAck==1 (stall ignored) -> next edge: state<=RUN, trap<=0, trapCause<=00, stackDepth<=0.
  - pcOut stays TRAP_VECTOR so the handler continues from there.
- stall==1 in RUN: pcOut, stack and stackDepth all hold.
- pcWrite==0: everything holds.
- Reset asserted mid-operation overrides all state immediately, including TRAP.

Optional Feature:
PC_TRACE_EN
- Defined:
  - adds output lastFrom (WIDTH): pcOut sampled at the most recent qualified write whose next PC != pcOut+1, including ret and trap entry.
  - adds output redirectCount (16): saturating count of such redirects; saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset with RESET_VECTOR=0; pcWrite=1, pcSrc=000 for 3 cycles -> pcOut 0,1,2,3; stackDepth=0.
- pcOut=0x0010, pcSrc=110, immAddr=0x0040:
  - comp=0 -> pcOut=0x0011.
  - then comp=1 -> 0x0040.
  - then pcSrc=111, immAddr=0x0003 -> 0x0030.
- pcOut=0x0020, call=1, pcSrc=010, immAddr=0x0100 -> pcOut=0x0100, depth=1. Then ret=1 -> pcOut=0x0021, depth=0.
- STACK_DEPTH=8, 8 calls then a 9th:
  - 9th call -> pcOut=0xFFF0, trap=1, trapCause=01, depth=8.
  - pcWrite ignored while in TRAP.
  - trapAck=1 -> trap=0, depth=0, pcOut=0xFFF0.
- ret with depth 0 -> trap=1, trapCause=10. stall=1 with pcWrite=1 in RUN -> pcOut unchanged for all stalled cycles.
- WIDTH=16, pcOut=0xFFFF, pcSrc=000 -> pcOut=0x0000. Assert reset mid-TRAP -> pcOut=RESET_VECTOR, trap=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/fetch bundle for the program-counter unit
// Carries lastFrom/redirectCount only when PC_TRACE_EN is defined.
interface pc_unit_if #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 8
);
  logic [2:0]                     pcSrc;
  logic [WIDTH-1:0]               immAddr;
  logic [WIDTH-1:0]               ra;
  logic [WIDTH-1:0]               mary;
  logic                           comp;
  logic                           pcWrite;
  logic                           stall;
  logic                           call;
  logic                           ret;
  logic                           trapAck;
  logic [WIDTH-1:0]               pcOut;
  logic [$clog2(STACK_DEPTH):0]   stackDepth;
  logic                           trap;
  logic [1:0]                     trapCause;
`ifdef PC_TRACE_EN
  logic [WIDTH-1:0]               lastFrom;
  logic [15:0]                    redirectCount;
`endif

  modport master (
    output pcSrc, immAddr, ra, mary, comp, pcWrite, stall, call, ret, trapAck,
`ifdef PC_TRACE_EN
    input  lastFrom, redirectCount,
`endif
    input  pcOut, stackDepth, trap, trapCause
  );

  modport slave (
    input  pcSrc, immAddr, ra, mary, comp, pcWrite, stall, call, ret, trapAck,
`ifdef PC_TRACE_EN
    output lastFrom, redirectCount,
`endif
    output pcOut, stackDepth, trap, trapCause
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with return-address stack and overflow/underflow trap
// Optional redirect trace (lastFrom, redirectCount) enabled by PC_TRACE_EN.
module pc_unit #(
  parameter int               WIDTH        = 16,
  parameter int               STACK_DEPTH  = 8,
  parameter int               SHIFT        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [15:0]      TRAP_VECTOR  = 16'hFFF0
) (
  input  logic clock,
  input  logic reset,
  pc_unit_if.slave bus
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0]    FULL = DW'(STACK_DEPTH);
  localparam logic [WIDTH-1:0] TVEC = WIDTH'(TRAP_VECTOR);

  typedef enum logic {RUN, TRAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic             trap_q;
  logic [1:0]       cause_q;

  logic [WIDTH-1:0] inc, target, next_pc;
  logic [PW-1:0]    top_idx, push_idx;
  logic             qw, ovf, unf;

  assign qw       = bus.pcWrite & ~bus.stall & (state == RUN);
  assign inc      = pc + 1'b1;
  assign top_idx  = PW'(depth - 1'b1);
  assign push_idx = depth[PW-1:0];
  assign ovf      = qw & bus.call & ~bus.ret & (depth == FULL);
  assign unf      = qw & bus.ret & (depth == '0);

  always_comb begin
    target = inc;
    case (bus.pcSrc)
      3'b000: target = inc;
      3'b001: target = pc + bus.immAddr;
      3'b010: target = bus.immAddr;
      3'b011: target = bus.ra;
      3'b100: target = bus.mary;
      3'b101: target = pc + (bus.mary << SHIFT);
      3'b110: target = bus.comp ? bus.immAddr : inc;
      3'b111: target = bus.comp ? (bus.immAddr << SHIFT) : inc;
      default: target = inc;
    endcase
  end

  // Trap entry wins over everything; a ret (alone or with call) takes the old top.
  always_comb begin
    next_pc = target;
    if (ovf || unf)
      next_pc = TVEC;
    else if (bus.ret)
      next_pc = stack[top_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      pc      <= RESET_VECTOR;
      depth   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
      for (int i = 0; i < STACK_DEPTH; i++)
        stack[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ovf || unf) begin
            pc      <= TVEC;
            state   <= TRAP;
            trap_q  <= 1'b1;
            cause_q <= unf ? 2'b10 : 2'b01;
          end else if (qw) begin
            pc <= next_pc;
            if (bus.ret && bus.call)
              stack[top_idx] <= inc;
            else if (bus.ret)
              depth <= depth - 1'b1;
            else if (bus.call) begin
              stack[push_idx] <= inc;
              depth           <= depth + 1'b1;
            end
          end
        end
        TRAP: begin
          if (bus.trapAck) begin
            state   <= RUN;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
            depth   <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.pcOut      = pc;
  assign bus.stackDepth = depth;
  assign bus.trap       = trap_q;
  assign bus.trapCause  = cause_q;

`ifdef PC_TRACE_EN
  logic [WIDTH-1:0] last_from;
  logic [15:0]      redirect_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_from    <= '0;
      redirect_cnt <= '0;
    end else if (qw && (next_pc != inc)) begin
      last_from <= pc;
      if (redirect_cnt != 16'hFFFF)
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

  assign bus.lastFrom      = last_from;
  assign bus.redirectCount = redirect_cnt;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized and directed bench for pc_unit against a queue-based model
module tb_pc_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  pc_unit_if #(.WIDTH(16), .STACK_DEPTH(8)) bus ();
  pc_unit #(.WIDTH(16), .STACK_DEPTH(8), .SHIFT(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model state
  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_trap;
  int unsigned m_cause;
  int unsigned m_last;
  int unsigned m_cnt;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_stk.delete(); m_trap = 0; m_cause = 0; m_last = 0; m_cnt = 0;
  endtask

  task automatic check_all(string tag);
    check({tag, ".pc"},    32'(bus.pcOut),      m_pc);
    check({tag, ".depth"}, 32'(bus.stackDepth), m_stk.size());
    check({tag, ".trap"},  32'(bus.trap),       32'(m_trap));
    check({tag, ".cause"}, 32'(bus.trapCause),  m_cause);
`ifdef PC_TRACE_EN
    check({tag, ".last"},  32'(bus.lastFrom),      m_last);
    check({tag, ".cnt"},   32'(bus.redirectCount), m_cnt);
`endif
  endtask

  task automatic step(string tag, logic [2:0] src, logic [15:0] imm, bit c, bit w, bit st,
                      bit cl, bit rt, bit ack);
    int unsigned inc, tgt, nxt, ra_v, mary_v;
    ra_v   = $urandom_range(0, 16'hFFFF);
    mary_v = $urandom_range(0, 16'hFFFF);
    bus.pcSrc = src; bus.immAddr = imm; bus.comp = c; bus.pcWrite = w; bus.stall = st;
    bus.call = cl; bus.ret = rt; bus.trapAck = ack;
    bus.ra = 16'(ra_v); bus.mary = 16'(mary_v);
    inc = (m_pc + 1) % 65536;
    case (src)
      3'd0: tgt = inc;
      3'd1: tgt = (m_pc + imm) % 65536;
      3'd2: tgt = imm;
      3'd3: tgt = ra_v;
      3'd4: tgt = mary_v;
      3'd5: tgt = (m_pc + mary_v * 16) % 65536;
      3'd6: tgt = c ? imm : inc;
      default: tgt = c ? (imm * 16) % 65536 : inc;
    endcase
    if (m_trap) begin
      if (ack) begin
        m_trap = 0; m_cause = 0; m_stk.delete();
      end
    end else if (w && !st) begin
      if (rt && m_stk.size() == 0) begin
        nxt = 16'hFFF0; m_trap = 1; m_cause = 2;
      end else if (cl && !rt && m_stk.size() == 8) begin
        nxt = 16'hFFF0; m_trap = 1; m_cause = 1;
      end else if (rt) begin
        nxt = m_stk[$];
        if (cl) m_stk[$] = inc;
        else    void'(m_stk.pop_back());
      end else begin
        nxt = tgt;
        if (cl) m_stk.push_back(inc);
      end
      if (nxt != inc) begin
        m_last = m_pc;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      m_pc = nxt;
    end
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.pcSrc = 0; bus.immAddr = 0; bus.ra = 0; bus.mary = 0; bus.comp = 0;
    bus.pcWrite = 0; bus.stall = 0; bus.call = 0; bus.ret = 0; bus.trapAck = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 1; i <= 3; i++) begin
      step("seq", 3'b000, 0, 0, 1, 0, 0, 0, 0);
      check("seq.const", 32'(bus.pcOut), i);
    end

    step("jmp",  3'b010, 16'h0010, 0, 1, 0, 0, 0, 0);
    step("bnt",  3'b110, 16'h0040, 0, 1, 0, 0, 0, 0);
    check("bnt.const", 32'(bus.pcOut), 32'h0011);
    step("bt",   3'b110, 16'h0040, 1, 1, 0, 0, 0, 0);
    check("bt.const", 32'(bus.pcOut), 32'h0040);
    step("bts",  3'b111, 16'h0003, 1, 1, 0, 0, 0, 0);
    check("bts.const", 32'(bus.pcOut), 32'h0030);

    step("jmp2", 3'b010, 16'h0020, 0, 1, 0, 0, 0, 0);
    step("call", 3'b010, 16'h0100, 0, 1, 0, 1, 0, 0);
    check("call.const", 32'(bus.pcOut), 32'h0100);
    step("ret",  3'b000, 0, 0, 1, 0, 0, 1, 0);
    check("ret.const", 32'(bus.pcOut), 32'h0021);

    for (int i = 0; i < 9; i++) step("ovf", 3'b000, 0, 0, 1, 0, 1, 0, 0);
    check("ovf.cause", 32'(bus.trapCause), 32'd1);
    check("ovf.depth", 32'(bus.stackDepth), 32'd8);
    step("trapwr", 3'b010, 16'h1234, 0, 1, 0, 1, 1, 0);
    step("ack",    3'b000, 0, 0, 1, 0, 0, 0, 1);
    check("ack.pc", 32'(bus.pcOut), 32'hFFF0);

    step("unf", 3'b000, 0, 0, 1, 0, 0, 1, 0);
    check("unf.cause", 32'(bus.trapCause), 32'd2);
    step("ack2", 3'b000, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("stall", 3'b010, 16'h5555, 0, 1, 1, 1, 0, 0);
    check("stall.pc", 32'(bus.pcOut), 32'hFFF0);

    step("top",  3'b010, 16'hFFFF, 0, 1, 0, 0, 0, 0);
    step("wrap", 3'b000, 0, 0, 1, 0, 0, 0, 0);
    check("wrap.const", 32'(bus.pcOut), 32'h0000);
    step("unf2", 3'b000, 0, 0, 1, 0, 1, 1, 0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 3000; i++) begin
      step("rand", 3'($urandom_range(0, 7)), 16'($urandom_range(0, 16'hFFFF)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
